// File: rtl/mips_mem_stall_pkg.sv
// Shared definitions for the CPU data-memory stall controller.
//   state_t       : controller FSM states (IDLE, WAIT, DONE)
//   TIMEOUT_RDATA : value returned to the CPU when an access is abandoned
//   CNT_W         : width of the WAIT-cycle counter
package mips_mem_stall_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;
  localparam int          CNT_W         = 8;

endpackage

// File: rtl/mips_cpu_wait_timer.sv
// WAIT-cycle counter for the stall controller.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   i_clear    : synchronous clear (dominates i_enable)
//   i_enable   : count one WAIT cycle
//   o_tc       : high during the MAX_WAIT-th enabled cycle since the clear
module mips_cpu_wait_timer
  import mips_mem_stall_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  // The count holds the number of WAIT cycles already elapsed, so the
  // current cycle is the MAX_WAIT-th one when the count equals MAX_WAIT-1.
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = i_enable && (r_count == TC_VAL);

endmodule

// File: rtl/mips_cpu_mem_stall.sv
// Stalls a MIPS CPU (via its clk_enable) while a data access is carried out
// on a slow, variable-latency data memory, with a WAIT timeout.
// Ports:
//   clk, reset               : clock, asynchronous active-low reset
//   cpu_active               : CPU running; gates new accesses
//   cpu_data_address/_write/_read/_writedata : CPU data-port request
//   cpu_data_readdata        : read data returned to the CPU
//   cpu_clk_enable           : 0 stalls the CPU
//   mem_req/mem_we/mem_addr/mem_wdata : request to memory
//   mem_ack/mem_rdata        : completion pulse and read data from memory
//   timeout_err              : sticky, set when an access is abandoned
//   dbg_state                : current FSM state
//
// Memory handshake: mem_req is held high (with mem_we/mem_addr/mem_wdata
// stable) for every WAIT cycle; the memory answers with a single-cycle
// mem_ack, mem_rdata valid in that cycle. An ack seen in any other state is
// ignored, so a late ack after a timeout or reset cannot corrupt anything.
module mips_cpu_mem_stall
  import mips_mem_stall_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_active,
  input  logic [31:0] cpu_data_address,
  input  logic        cpu_data_write,
  input  logic        cpu_data_read,
  input  logic [31:0] cpu_data_writedata,
  output logic [31:0] cpu_data_readdata,
  output logic        cpu_clk_enable,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        timeout_err,
  output state_t      dbg_state
);

  state_t      r_state;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_timeout;

  logic w_start;
  logic w_tc;
  logic w_clk_en;

  assign w_start = cpu_active && (cpu_data_read || cpu_data_write);

  mips_cpu_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (reset),
    .i_clear  ((r_state == IDLE) && w_start),
    .i_enable (r_state == WAIT),
    .o_tc     (w_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= WAIT;
            r_we    <= cpu_data_write;  // write wins over read
            r_addr  <= cpu_data_address;
            r_wdata <= cpu_data_writedata;
          end
        end
        WAIT: begin
          // An ack in the terminal-count cycle still completes normally.
          if (mem_ack) begin
            if (!r_we) r_rdata <= mem_rdata;
            r_state <= DONE;
          end else if (w_tc) begin
            r_rdata   <= TIMEOUT_RDATA;
            r_timeout <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          // The CPU advances on this edge; its strobes are still those of
          // the finished access, so never re-trigger from DONE.
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The stall must take effect in the request cycle itself, so the clock
  // enable is combinational; reset forces it high regardless of strobes.
  always_comb begin
    w_clk_en = 1'b1;
    case (r_state)
      IDLE:    w_clk_en = !w_start;
      WAIT:    w_clk_en = 1'b0;
      default: w_clk_en = 1'b1;
    endcase
    if (!reset) w_clk_en = 1'b1;
  end

  assign cpu_clk_enable    = w_clk_en;
  assign mem_req           = (r_state == WAIT);
  assign mem_we            = r_we;
  assign mem_addr          = r_addr;
  assign mem_wdata         = r_wdata;
  assign cpu_data_readdata = r_rdata;
  assign timeout_err       = r_timeout;
  assign dbg_state         = r_state;

endmodule

// File: tb/tb_mips_cpu_mem_stall.sv
module tb_mips_cpu_mem_stall;
  import mips_mem_stall_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_active = 1'b0;
  logic [31:0] cpu_data_address = '0;
  logic        cpu_data_write = 1'b0;
  logic        cpu_data_read = 1'b0;
  logic [31:0] cpu_data_writedata = '0;
  logic [31:0] cpu_data_readdata;
  logic        cpu_clk_enable;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        timeout_err;
  state_t      dbg_state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_cpu_mem_stall #(.MAX_WAIT(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .cpu_active         (cpu_active),
    .cpu_data_address   (cpu_data_address),
    .cpu_data_write     (cpu_data_write),
    .cpu_data_read      (cpu_data_read),
    .cpu_data_writedata (cpu_data_writedata),
    .cpu_data_readdata  (cpu_data_readdata),
    .cpu_clk_enable     (cpu_clk_enable),
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_ack            (mem_ack),
    .mem_rdata          (mem_rdata),
    .timeout_err        (timeout_err),
    .dbg_state          (dbg_state)
  );

  // ---------------- driver tasks ----------------
  // Advance to 2ns after the next rising edge; inputs are changed there and
  // outputs sampled 1ns later, well away from the active edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issue one CPU access and act as the memory: ack in WAIT cycle ack_at
  // (0 = never). Returns what was observed; callers do the comparisons.
  task automatic run_access(
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  int          ack_at,
    input  logic [31:0] rdata,
    output int          stall,
    output int          waits,
    output logic        done_ok,
    output logic [31:0] rd_done,
    output logic        we_seen,
    output logic [31:0] addr_seen,
    output logic [31:0] wdata_seen,
    output logic        req_ok
  );
    tick();
    cpu_active = 1'b1;
    cpu_data_read = rd;
    cpu_data_write = wr;
    cpu_data_address = addr;
    cpu_data_writedata = wdata;
    #1;
    stall = cpu_clk_enable ? 0 : 1;
    waits = 0;
    done_ok = 1'b0;
    req_ok = 1'b1;
    rd_done = '0;
    we_seen = 1'b0;
    addr_seen = '0;
    wdata_seen = '0;
    for (int c = 0; c < 40; c++) begin
      tick();
      mem_ack = 1'b0;
      if (dbg_state == WAIT) begin
        waits++;
        mem_ack = (waits == ack_at);
        mem_rdata = rdata;
      end
      #1;
      if (!cpu_clk_enable) stall++;
      if (dbg_state == WAIT) begin
        if (!mem_req) req_ok = 1'b0;
        if (waits == 1) begin
          we_seen = mem_we;
          addr_seen = mem_addr;
          wdata_seen = mem_wdata;
        end else if (mem_we !== we_seen || mem_addr !== addr_seen ||
                     mem_wdata !== wdata_seen) begin
          req_ok = 1'b0;
        end
      end
      if (dbg_state == DONE) begin
        done_ok = 1'b1;
        rd_done = cpu_data_readdata;
        if (mem_req || !cpu_clk_enable) req_ok = 1'b0;
        break;
      end
    end
    // CPU advances out of DONE and drops its strobes.
    tick();
    cpu_data_read = 1'b0;
    cpu_data_write = 1'b0;
    mem_ack = 1'b0;
    #1;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    reset = 1'b0;
    cpu_active = 1'b1;
    cpu_data_read = 1'b1;  // strobes during reset must not stall
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (cpu_clk_enable !== 1'b1 || mem_req !== 1'b0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_ctrl: clk_en=%b req=%b state=%0d, want 1 0 0",
               cpu_clk_enable, mem_req, dbg_state);
    end
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
        cpu_data_readdata !== 32'h0 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_data: we=%b addr=%h wdata=%h rdata=%h terr=%b, want all zero",
               mem_we, mem_addr, mem_wdata, cpu_data_readdata, timeout_err);
    end
    cpu_data_read = 1'b0;
    cpu_active = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  task automatic test_idle_inactive();
    tick();
    cpu_active = 1'b0;
    cpu_data_read = 1'b1;
    cpu_data_address = 32'h0000_0040;
    #1;
    checks++;
    if (cpu_clk_enable !== 1'b1 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL inactive_no_stall: clk_en=%b req=%b, want 1 0", cpu_clk_enable, mem_req);
    end
    tick();
    #1;
    checks++;
    if (dbg_state !== IDLE || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL inactive_stay_idle: state=%0d req=%b, want 0 0", dbg_state, mem_req);
    end
    cpu_data_read = 1'b0;
  endtask

  task automatic test_read();
    int st, wt;
    logic ok, we, rq;
    logic [31:0] rd, ad, wd;
    run_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 2, 32'hCAFE_F00D,
               st, wt, ok, rd, we, ad, wd, rq);
    checks++;
    if (!ok || rd !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL read_data: done=%b rdata=%h, want 1 cafef00d", ok, rd);
    end
    checks++;
    if (st != 3) begin
      failures++;
      $display("FAIL read_stall: stall=%0d, want 3", st);
    end
    checks++;
    if (we !== 1'b0 || ad !== 32'h0000_0010 || !rq) begin
      failures++;
      $display("FAIL read_req: we=%b addr=%h req_ok=%b, want 0 00000010 1", we, ad, rq);
    end
    checks++;
    if (dbg_state !== IDLE || cpu_clk_enable !== 1'b1 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL read_back_idle: state=%0d clk_en=%b req=%b, want 0 1 0",
               dbg_state, cpu_clk_enable, mem_req);
    end
  endtask

  task automatic test_write();
    int st, wt;
    logic ok, we, rq;
    logic [31:0] rd, ad, wd;
    run_access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 1, 32'hDEAD_BEEF,
               st, wt, ok, rd, we, ad, wd, rq);
    checks++;
    if (we !== 1'b1 || wd !== 32'h1234_5678 || ad !== 32'h0000_0020 || !rq) begin
      failures++;
      $display("FAIL write_req: we=%b wdata=%h addr=%h req_ok=%b, want 1 12345678 00000020 1",
               we, wd, ad, rq);
    end
    checks++;
    if (!ok || st != 2) begin
      failures++;
      $display("FAIL write_stall: done=%b stall=%0d, want 1 2", ok, st);
    end
    checks++;
    if (rd !== 32'hCAFE_F00D || cpu_data_readdata !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL write_keeps_rdata: done=%h now=%h, want cafef00d", rd, cpu_data_readdata);
    end
  endtask

  task automatic test_both_tc_ack();
    int st, wt;
    logic ok, we, rq;
    logic [31:0] rd, ad, wd;
    run_access(1'b1, 1'b1, 32'h0000_0030, 32'hA1B2_C3D4, 4, 32'h0BAD_0BAD,
               st, wt, ok, rd, we, ad, wd, rq);
    checks++;
    if (we !== 1'b1 || wd !== 32'hA1B2_C3D4) begin
      failures++;
      $display("FAIL both_write_wins: we=%b wdata=%h, want 1 a1b2c3d4", we, wd);
    end
    checks++;
    if (!ok || wt != 4 || st != 5 || !rq) begin
      failures++;
      $display("FAIL tc_ack_timing: done=%b waits=%0d stall=%0d req_ok=%b, want 1 4 5 1",
               ok, wt, st, rq);
    end
    checks++;
    if (timeout_err !== 1'b0 || rd !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL tc_ack_no_err: terr=%b rdata=%h, want 0 cafef00d", timeout_err, rd);
    end
  endtask

  task automatic test_timeout();
    int st, wt;
    logic ok, we, rq;
    logic [31:0] rd, ad, wd;
    run_access(1'b1, 1'b0, 32'h0000_0050, 32'h0, 0, 32'h1111_2222,
               st, wt, ok, rd, we, ad, wd, rq);
    checks++;
    if (!ok || wt != 4 || st != 5) begin
      failures++;
      $display("FAIL timeout_timing: done=%b waits=%0d stall=%0d, want 1 4 5", ok, wt, st);
    end
    checks++;
    if (rd !== 32'hFFFF_FFFF || timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_result: rdata=%h terr=%b, want ffffffff 1", rd, timeout_err);
    end
    // Late ack two cycles after DONE.
    tick();
    mem_ack = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    #1;
    tick();
    mem_ack = 1'b0;
    #1;
    checks++;
    if (dbg_state !== IDLE || mem_req !== 1'b0 || cpu_data_readdata !== 32'hFFFF_FFFF ||
        timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL late_ack_ignored: state=%0d req=%b rdata=%h terr=%b, want 0 0 ffffffff 1",
               dbg_state, mem_req, cpu_data_readdata, timeout_err);
    end
  endtask

  task automatic test_active_drop_in_wait();
    tick();
    cpu_active = 1'b1;
    cpu_data_read = 1'b1;
    cpu_data_address = 32'h0000_0060;
    tick();  // now WAIT
    cpu_active = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hA5A5_5A5A;
    #1;
    checks++;
    if (dbg_state !== WAIT || mem_req !== 1'b1 || cpu_clk_enable !== 1'b0) begin
      failures++;
      $display("FAIL active_drop_wait: state=%0d req=%b clk_en=%b, want 1 1 0",
               dbg_state, mem_req, cpu_clk_enable);
    end
    tick();
    mem_ack = 1'b0;
    #1;
    checks++;
    if (dbg_state !== DONE || cpu_data_readdata !== 32'hA5A5_5A5A) begin
      failures++;
      $display("FAIL active_drop_done: state=%0d rdata=%h, want 2 a5a55a5a",
               dbg_state, cpu_data_readdata);
    end
    tick();
    cpu_data_read = 1'b0;
    #1;
  endtask

  task automatic test_reset_in_wait();
    tick();
    cpu_active = 1'b1;
    cpu_data_read = 1'b1;
    cpu_data_address = 32'h0000_0070;
    tick();  // WAIT cycle 1
    tick();  // WAIT cycle 2
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || cpu_clk_enable !== 1'b1) begin
      failures++;
      $display("FAIL reset_wait_immediate: req=%b clk_en=%b, want 0 1", mem_req, cpu_clk_enable);
    end
    cpu_data_read = 1'b0;
    cpu_active = 1'b0;
    tick();
    reset = 1'b1;
    mem_ack = 1'b1;  // ack arriving after reset
    mem_rdata = 32'h7777_7777;
    tick();
    mem_ack = 1'b0;
    #1;
    checks++;
    if (dbg_state !== IDLE || mem_req !== 1'b0 || cpu_clk_enable !== 1'b1 ||
        mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
        cpu_data_readdata !== 32'h0 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_wait_release: state=%0d req=%b en=%b we=%b addr=%h wd=%h rd=%h terr=%b, want reset values",
               dbg_state, mem_req, cpu_clk_enable, mem_we, mem_addr, mem_wdata,
               cpu_data_readdata, timeout_err);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    fork
      begin
        test_reset();
        test_idle_inactive();
        test_read();
        test_write();
        test_both_tc_ack();
        test_timeout();
        test_active_drop_in_wait();
        test_reset_in_wait();
      end
      begin
        #100000;
        failures++;
        $display("FAIL global_timeout: run exceeded time limit");
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_cpu_mem_stall.md
MIPS_CPU_MEM_STALL -- requirements
Module: mips_cpu_mem_stall

Interface
REQ-001 The block SHALL have parameter MAX_WAIT, default 16, meaning the maximum number of WAIT cycles before a memory access is abandoned (legal range 1..255).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; no other clock or reset SHALL exist.
REQ-003 clk  input  1  rising-edge clock shared with mips_cpu_harvard.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cpu_active  input  1  CPU active flag.
REQ-006 cpu_data_address  input  32  CPU data address.
REQ-007 cpu_data_write  input  1  CPU write strobe.
REQ-008 cpu_data_read  input  1  CPU read strobe.
REQ-009 cpu_data_writedata  input  32  CPU write data.
REQ-010 cpu_data_readdata  output  32  read data returned to the CPU.
REQ-011 cpu_clk_enable  output  1  drives the CPU clk_enable; 0 stalls the CPU.
REQ-012 mem_req  output  1  request valid to the slow data memory.
REQ-013 mem_we  output  1  1 = write, 0 = read.
REQ-014 mem_addr  output  32  request address.
REQ-015 mem_wdata  output  32  request write data.
REQ-016 mem_ack  input  1  one-cycle completion pulse from memory.
REQ-017 mem_rdata  input  32  read data, valid when mem_ack=1.
REQ-018 timeout_err  output  1  sticky timeout flag.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, WAIT and DONE.
REQ-020 In IDLE with cpu_active=1 and (cpu_data_read or cpu_data_write), cpu_clk_enable SHALL be 0 combinationally in that same cycle, and the FSM SHALL enter WAIT.
REQ-021 On the IDLE->WAIT edge, address, write data and mem_we SHALL be registered; mem_we=1 when cpu_data_write=1 (write wins when both strobes are high).
REQ-022 In WAIT, mem_req SHALL be 1, cpu_clk_enable SHALL be 0, and mem_addr, mem_wdata and mem_we SHALL remain stable.
REQ-023 In WAIT with mem_ack=1, the FSM SHALL latch mem_rdata (reads only) into cpu_data_readdata and enter DONE.
REQ-024 In DONE, cpu_clk_enable SHALL be 1 and mem_req SHALL be 0; the FSM SHALL return to IDLE unconditionally, without re-triggering on the strobes still asserted in DONE.
REQ-025 Latency: request in cycle 0, mem_req from cycle 1, ack in cycle k>=1, DONE in cycle k+1; minimum stall = 2 cycles.
REQ-026 The WAIT cycle counter SHALL be 8 bits and clear on entry to WAIT; if it reaches MAX_WAIT without mem_ack, the FSM SHALL enter DONE with cpu_data_readdata=32'hFFFFFFFF and set timeout_err.
REQ-027 If mem_ack arrives in the same cycle the counter reaches MAX_WAIT, the ack SHALL win (normal completion, no error).
REQ-028 mem_ack in IDLE or DONE (for example a late ack after a timeout) SHALL be ignored.
REQ-029 cpu_active=0 SHALL prevent new requests; an access already in WAIT SHALL complete normally.
REQ-030 In IDLE with no access, cpu_clk_enable SHALL be 1 and mem_req SHALL be 0.
REQ-031 cpu_data_readdata SHALL hold its last latched value outside DONE; writes SHALL NOT update it.

Reset
REQ-032 Asserting reset SHALL immediately force: state IDLE, counter 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_data_readdata 0, timeout_err 0, cpu_clk_enable 1.
REQ-033 Reset during WAIT SHALL drop mem_req without waiting for mem_ack; an ack arriving after reset SHALL be ignored.
REQ-034 timeout_err SHALL clear only on reset.

Structure
REQ-035 A shared package mips_mem_stall_pkg SHALL hold the state enum (IDLE, WAIT, DONE) and the constant TIMEOUT_RDATA = 32'hFFFFFFFF.
REQ-036 The WAIT counter SHALL be one sub-module, mips_cpu_wait_timer (clear, enable, terminal-count output); all other logic SHALL be inline.

Verification
REQ-037 Read at 0x00000010, ack with 0xCAFEF00D two cycles after mem_req rises -> cpu_clk_enable low for 3 cycles, readdata=0xCAFEF00D in DONE, mem_we=0.
REQ-038 Write 0x12345678 to 0x00000020 with ack in the first WAIT cycle -> mem_we=1, mem_wdata=0x12345678, stall exactly 2 cycles, readdata unchanged.
REQ-039 Read with no ack, MAX_WAIT=4 -> DONE after 4 WAIT cycles, readdata=0xFFFFFFFF, timeout_err=1; a late ack 2 cycles later has no effect.
REQ-040 Read and write asserted together -> mem_we=1; ack coinciding with terminal count -> timeout_err stays 0.
REQ-041 reset asserted in the 2nd WAIT cycle -> mem_req=0 and cpu_clk_enable=1 immediately; after release, state IDLE and all outputs at reset values.
